// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles the two requester handshakes (instruction fetch, data memory), the
// shared memory port and the status outputs of mem_port_arbiter.
//
// Modports:
//   master - arbiter side. Takes the requests and the memory response, and
//            drives the memory request, the acks, the read data, the stalls
//            and timeout_err.
//   slave  - environment side. Pipeline stages plus the memory model: they
//            drive the requests and the memory response.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  // Instruction fetch requester (read-only)
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  // Data-memory requester (read/write)
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  // Shared memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // Pipeline status
  logic              stall_if;
  logic              stall_dm;
  logic              timeout_err;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
    output stall_if, stall_dm, timeout_err
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
    input  stall_if, stall_dm, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between instruction fetch (IF) and the data-memory
// stage (DM). Each access runs IDLE -> BUSY_x -> DONE -> IDLE. A wait counter
// aborts an access that sees no mem_ack within TIMEOUT busy cycles. The abort
// completes with zero read data and sets the sticky timeout_err flag.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - mem_port_arbiter_if.master. Carries the requester handshakes, the
//          registered memory port, the combinational stalls and timeout_err.
//
// Build option:
//   MCPU_ARB_RR_EN - when defined, simultaneous IF+DM requests alternate via a
//                    last-grant pointer. Otherwise DM always wins ties.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15   // 1..255
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyDm, StDone} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_ack_q;
  logic              dm_ack_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              timeout_err_q;
  logic              grant_dm;

`ifdef MCPU_ARB_RR_EN
  logic last_dm_q;  // 1: DM was granted last, 0: IF (reset value)

  always_comb begin
    grant_dm = bus.dm_req;
    if (bus.dm_req && bus.if_req) begin
      grant_dm = ~last_dm_q;
    end
  end
`else
  always_comb begin
    grant_dm = bus.dm_req;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      if_ack_q      <= 1'b0;
      dm_ack_q      <= 1'b0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
      timeout_err_q <= 1'b0;
`ifdef MCPU_ARB_RR_EN
      last_dm_q     <= 1'b0;
`endif
    end else begin
      // Acks are single-cycle pulses: only the completing edge raises them.
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.if_req || bus.dm_req) begin
            cnt_q     <= '0;
            mem_req_q <= 1'b1;
            if (grant_dm) begin
              state_q     <= StBusyDm;
              mem_we_q    <= bus.dm_we;
              mem_addr_q  <= bus.dm_addr;
              mem_wdata_q <= bus.dm_wdata;
            end else begin
              state_q     <= StBusyIf;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= bus.if_addr;
              mem_wdata_q <= '0;
            end
`ifdef MCPU_ARB_RR_EN
            last_dm_q <= grant_dm;
`endif
          end
        end
        StBusyIf, StBusyDm: begin
          // A mem_ack on the same edge as the timeout wins.
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= StDone;
            if (state_q == StBusyIf) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end else begin
              dm_ack_q <= 1'b1;
              // Writes return no data; keep the last read value.
              if (!mem_we_q) begin
                dm_rdata_q <= bus.mem_rdata;
              end
            end
          end else if (cnt_q == TimeoutLast) begin
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= StDone;
            if (state_q == StBusyIf) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= '0;
            end else begin
              dm_ack_q   <= 1'b1;
              dm_rdata_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        // One dead cycle so a requester still holding req is not re-granted.
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.if_ack      = if_ack_q;
  assign bus.dm_ack      = dm_ack_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.dm_rdata    = dm_rdata_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.stall_if    = bus.if_req & ~if_ack_q;
  assign bus.stall_dm    = bus.dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. The bench plays both pipeline
// requesters and the memory. It keeps a transaction-level reference: who was
// served last, the word memory contents, and the last data returned to each
// requester. Inputs change on the falling edge. Outputs are sampled on the
// falling edge too.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned TMO = 15;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  bit          last_dm;                  // requester served last (0 = IF)
  logic [15:0] exp_if_rdata;
  logic [15:0] exp_dm_rdata;
  bit   [15:0] mem_model [bit [15:0]];

  // Tie rule: round-robin alternates, fixed priority favours DM.
  function automatic bit pick_dm(bit ifr, bit dmr);
`ifdef MCPU_ARB_RR_EN
    if (ifr && dmr) return !last_dm;
`endif
    return dmr;
  endfunction

  function automatic logic [15:0] model_read(logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 16'h5A5A;
  endfunction

  task automatic drive_idle();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic model_reset();
    last_dm      = 1'b0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [68:0] outs;
    int hi;
    @(negedge clk);
    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 16'h1111;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 16'h2222; bus.dm_wdata = 16'h3333;
    repeat (2) @(negedge clk);
    outs = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_ack, bus.dm_ack,
            bus.if_rdata, bus.dm_rdata, bus.timeout_err};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", outs);
    end
    checks++;
    if ({bus.stall_if, bus.stall_dm} !== 2'b11) begin
      errors++; $display("FAIL reset_stalls got %b want 11", {bus.stall_if, bus.stall_dm});
    end
    drive_idle();
    rst = 1'b1;
    model_reset();
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_req !== 1'b0 || bus.if_ack !== 1'b0 || bus.dm_ack !== 1'b0) hi++;
    end
    checks++;
    if (hi != 0) begin
      errors++; $display("FAIL reset_quiet got %0d active cycles want 0", hi);
    end
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.stall_if} !== {1'b1, 1'b0, 16'h0010, 1'b1})
    begin
      errors++; $display("FAIL fetch_grant got req=%b we=%b addr=%h stall=%b want 1 0 0010 1",
                         bus.mem_req, bus.mem_we, bus.mem_addr, bus.stall_if);
    end
    last_dm = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.if_ack, bus.stall_if} !== 3'b101) begin
      errors++; $display("FAIL fetch_wait got req/ack/stall=%b want 101",
                         {bus.mem_req, bus.if_ack, bus.stall_if});
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1234;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    exp_if_rdata = 16'h1234;
    checks++;
    if ({bus.if_ack, bus.if_rdata, bus.stall_if, bus.mem_req} !== {1'b1, 16'h1234, 1'b0, 1'b0})
    begin
      errors++; $display("FAIL fetch_ack got ack=%b rdata=%h stall=%b req=%b want 1 1234 0 0",
                         bus.if_ack, bus.if_rdata, bus.stall_if, bus.mem_req);
    end
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.if_ack, bus.mem_req} !== 2'b00) begin
      errors++; $display("FAIL fetch_pulse got ack/req=%b want 00", {bus.if_ack, bus.mem_req});
    end
  endtask

  task automatic test_tie();
    bit first_dm;
    reset_dut();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 16'h8000; bus.dm_wdata = 16'hBEEF;
    bus.if_req = 1'b1; bus.if_addr = 16'h0020;
    first_dm = pick_dm(1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 16'h8000, 16'hBEEF}
        || first_dm !== 1'b1) begin
      errors++; $display("FAIL tie_first got req=%b we=%b addr=%h wdata=%h want 1 1 8000 beef",
                         bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    last_dm = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h7777;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    checks++;
    if ({bus.dm_ack, bus.if_ack, bus.dm_rdata, bus.mem_req} !== {2'b10, exp_dm_rdata, 1'b0}) begin
      errors++; $display("FAIL tie_dm_ack got dm_ack=%b if_ack=%b dm_rdata=%h req=%b want 1 0 %h 0",
                         bus.dm_ack, bus.if_ack, bus.dm_rdata, bus.mem_req, exp_dm_rdata);
    end
    bus.dm_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.dm_ack} !== 2'b00) begin
      errors++; $display("FAIL tie_gap got req/ack=%b want 00", {bus.mem_req, bus.dm_ack});
    end
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b10, 16'h0020, 16'h0000})
    begin
      errors++; $display("FAIL tie_if_grant got req=%b we=%b addr=%h wdata=%h want 1 0 0020 0000",
                         bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    last_dm = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hCAFE;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    exp_if_rdata = 16'hCAFE;
    checks++;
    if ({bus.if_ack, bus.if_rdata} !== {1'b1, 16'hCAFE}) begin
      errors++; $display("FAIL tie_if_ack got ack=%b rdata=%h want 1 cafe", bus.if_ack, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit win_dm;
    int w;
    logic [15:0] ia, da, rd;
    ia = 16'h0100; da = 16'h9000;
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = ia;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = da; bus.dm_wdata = 16'h0;
    for (int g = 0; g < 6; g++) begin
      win_dm = pick_dm(1'b1, 1'b1);
      w = 0;
      @(negedge clk);
      while (bus.mem_req !== 1'b1 && w < 6) begin @(negedge clk); w++; end
      checks++;
      if ({bus.mem_req, bus.mem_addr} !== {1'b1, (win_dm ? da : ia)}) begin
        errors++; $display("FAIL b2b_grant g=%0d got req=%b addr=%h want 1 %h",
                           g, bus.mem_req, bus.mem_addr, (win_dm ? da : ia));
      end
      last_dm = win_dm;
      rd = {4'hB, 12'(g)};
      bus.mem_ack = 1'b1; bus.mem_rdata = rd;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (win_dm) exp_dm_rdata = rd; else exp_if_rdata = rd;
      checks++;
      if ({bus.if_ack, bus.dm_ack, bus.if_rdata, bus.dm_rdata} !==
          {!win_dm, win_dm, exp_if_rdata, exp_dm_rdata}) begin
        errors++; $display("FAIL b2b_ack g=%0d got if=%b dm=%b %h %h want %b %b %h %h", g,
                           bus.if_ack, bus.dm_ack, bus.if_rdata, bus.dm_rdata,
                           !win_dm, win_dm, exp_if_rdata, exp_dm_rdata);
      end
      // The served requester immediately issues its next access.
      if (win_dm) begin da++; bus.dm_addr = da; end
      else begin ia++; bus.if_addr = ia; end
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got req=%b want 0", bus.mem_req);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int unsigned mode;
      bit ifr, dmr, srv_if, srv_dm, win_dm, dwe;
      logic [15:0] iaddr, daddr, dwdata, rd;
      logic [32:0] exp_f;
      int w, lat;
      mode   = $urandom_range(0, 2);
      ifr    = (mode != 1);
      dmr    = (mode != 0);
      dwe    = 1'($urandom_range(0, 1));
      iaddr  = 16'($urandom);
      daddr  = 16'($urandom);
      dwdata = 16'($urandom);
      srv_if = 1'b0; srv_dm = 1'b0;
      @(negedge clk);
      bus.if_req = ifr; bus.if_addr = iaddr;
      bus.dm_req = dmr; bus.dm_we = dwe; bus.dm_addr = daddr; bus.dm_wdata = dwdata;
      for (int n = 0; n < 2; n++) begin
        if ((ifr && !srv_if) || (dmr && !srv_dm)) begin
          win_dm = pick_dm(ifr && !srv_if, dmr && !srv_dm);
          w = 0;
          @(negedge clk);
          while (bus.mem_req !== 1'b1 && w < 6) begin @(negedge clk); w++; end
          checks++;
          if (bus.mem_req !== 1'b1 || w != n) begin
            errors++; $display("FAIL rand_grant it=%0d got req=%b wait=%0d want 1 %0d",
                               it, bus.mem_req, w, n);
          end
          exp_f = win_dm ? {dwe, daddr, dwdata} : {1'b0, iaddr, 16'h0000};
          checks++;
          if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== exp_f) begin
            errors++; $display("FAIL rand_fields it=%0d got %h want %h", it,
                               {bus.mem_we, bus.mem_addr, bus.mem_wdata}, exp_f);
          end
          last_dm = win_dm;
          lat = int'($urandom_range(0, 3));
          repeat (lat) @(negedge clk);
          checks++;
          if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, exp_f}) begin
            errors++; $display("FAIL rand_hold it=%0d got req=%b %h want 1 %h", it, bus.mem_req,
                               {bus.mem_we, bus.mem_addr, bus.mem_wdata}, exp_f);
          end
          if (win_dm && dwe) begin
            mem_model[daddr] = dwdata;
            rd = 16'($urandom);
          end else begin
            rd = model_read(win_dm ? daddr : iaddr);
          end
          bus.mem_ack = 1'b1; bus.mem_rdata = rd;
          @(negedge clk);
          bus.mem_ack = 1'b0;
          if (win_dm) begin
            if (!dwe) exp_dm_rdata = rd;
            srv_dm = 1'b1;
          end else begin
            exp_if_rdata = rd;
            srv_if = 1'b1;
          end
          checks++;
          if ({bus.if_ack, bus.dm_ack, bus.stall_if, bus.stall_dm, bus.mem_req} !==
              {!win_dm, win_dm, ifr && !srv_if, dmr && !srv_dm, 1'b0}) begin
            errors++; $display("FAIL rand_ack it=%0d got ack/stall/req=%b want %b", it,
                               {bus.if_ack, bus.dm_ack, bus.stall_if, bus.stall_dm, bus.mem_req},
                               {!win_dm, win_dm, ifr && !srv_if, dmr && !srv_dm, 1'b0});
          end
          checks++;
          if ({bus.if_rdata, bus.dm_rdata} !== {exp_if_rdata, exp_dm_rdata}) begin
            errors++; $display("FAIL rand_rdata it=%0d got %h %h want %h %h", it,
                               bus.if_rdata, bus.dm_rdata, exp_if_rdata, exp_dm_rdata);
          end
          if (win_dm) bus.dm_req = 1'b0; else bus.if_req = 1'b0;
        end
      end
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.if_ack, bus.dm_ack} !== 3'b000) begin
        errors++; $display("FAIL rand_done it=%0d got req/acks=%b want 000", it,
                           {bus.mem_req, bus.if_ack, bus.dm_ack});
      end
    end
  endtask

  task automatic test_timeout();
    int w, hi;
    // mem_ack arriving on the last allowed busy cycle completes normally.
    @(negedge clk);
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h4444; bus.dm_wdata = 16'h0;
    w = 0;
    @(negedge clk);
    while (bus.mem_req !== 1'b1 && w < 6) begin @(negedge clk); w++; end
    last_dm = 1'b1;
    hi = 1;
    for (int k = 1; k < int'(TMO); k++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) hi++;
    end
    checks++;
    if (hi != int'(TMO)) begin
      errors++; $display("FAIL tmo_edge_busy got %0d busy cycles want %0d", hi, TMO);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h0F0F;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    exp_dm_rdata = 16'h0F0F;
    checks++;
    if ({bus.dm_ack, bus.dm_rdata, bus.timeout_err} !== {1'b1, 16'h0F0F, 1'b0}) begin
      errors++; $display("FAIL tmo_ack_wins got ack=%b rdata=%h err=%b want 1 0f0f 0",
                         bus.dm_ack, bus.dm_rdata, bus.timeout_err);
    end
    bus.dm_req = 1'b0;
    repeat (2) @(negedge clk);
    // No mem_ack at all: abort after TIMEOUT busy cycles.
    bus.dm_req = 1'b1; bus.dm_addr = 16'h5555;
    w = 0;
    @(negedge clk);
    while (bus.mem_req !== 1'b1 && w < 6) begin @(negedge clk); w++; end
    hi = (bus.mem_req === 1'b1) ? 1 : 0;
    while (bus.mem_req === 1'b1 && hi < 40) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) hi++;
    end
    checks++;
    if (hi != int'(TMO)) begin
      errors++; $display("FAIL tmo_busy_len got %0d busy cycles want %0d", hi, TMO);
    end
    exp_dm_rdata = 16'h0000;
    checks++;
    if ({bus.dm_ack, bus.dm_rdata, bus.timeout_err} !== {1'b1, 16'h0000, 1'b1}) begin
      errors++; $display("FAIL tmo_abort got ack=%b rdata=%h err=%b want 1 0000 1",
                         bus.dm_ack, bus.dm_rdata, bus.timeout_err);
    end
    bus.dm_req = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({bus.timeout_err, bus.dm_ack, bus.mem_req} !== 3'b100) begin
      errors++; $display("FAIL tmo_sticky got err/ack/req=%b want 100",
                         {bus.timeout_err, bus.dm_ack, bus.mem_req});
    end
  endtask

  task automatic test_reset_mid();
    int hi, w;
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 16'h0300;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.mem_req, bus.timeout_err} !== 2'b00) begin
      errors++; $display("FAIL mid_reset_async got req/err=%b want 00",
                         {bus.mem_req, bus.timeout_err});
    end
    bus.if_req = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.if_ack !== 1'b0 || bus.mem_req !== 1'b0) hi++;
    end
    checks++;
    if (hi != 0 || bus.if_rdata !== exp_if_rdata) begin
      errors++; $display("FAIL mid_no_ack got %0d active cycles rdata=%h want 0 %h",
                         hi, bus.if_rdata, exp_if_rdata);
    end
    bus.if_req = 1'b1;
    w = 0;
    @(negedge clk);
    while (bus.mem_req !== 1'b1 && w < 6) begin @(negedge clk); w++; end
    checks++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 16'h0300} || w != 0) begin
      errors++; $display("FAIL mid_reissue got req=%b addr=%h wait=%0d want 1 0300 0",
                         bus.mem_req, bus.mem_addr, w);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hABCD;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    checks++;
    if ({bus.if_ack, bus.if_rdata} !== {1'b1, 16'hABCD}) begin
      errors++; $display("FAIL mid_complete got ack=%b rdata=%h want 1 abcd",
                         bus.if_ack, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    drive_idle();
    model_reset();
    test_reset();
    test_single_fetch();
    test_tie();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single 16-bit memory port between two requesters: instruction fetch (IF, read-only) and the data-memory stage (DM, read/write).
- Sequences each access with a req/ack handshake and a bounded-wait timeout.
- Generates stall requests back to the pipeline so IF/DM hold while waiting.
- Sits between the mcpu pipeline stages and the external memory model.

Parameters:
- ADDR_W, 16, address width of all ports.
- DATA_W, 16, data width of all ports.
- TIMEOUT, 15, max cycles in a BUSY state without mem_ack before abort (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  ADDR_W  fetch address, stable while if_req.
- if_rdata  out  DATA_W  fetched word, valid when if_ack.
- if_ack  out  1  one-cycle completion pulse.
- dm_req  in  1  data request, held until dm_ack.
- dm_we  in  1  1=write, 0=read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_rdata  out  DATA_W  read data, valid when dm_ack.
- dm_ack  out  1  one-cycle completion pulse.
- mem_req  out  1  memory access request (registered).
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_rdata  in  DATA_W  memory read data, sampled with mem_ack.
- mem_ack  in  1  memory completion, one cycle.
- stall_if  out  1  = if_req & ~if_ack (combinational).
- stall_dm  out  1  = dm_req & ~dm_ack (combinational).
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all registered outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata, timeout_err); wait counter 0; RR pointer = IF.
- FSM states: IDLE, BUSY_IF, BUSY_DM, DONE.
- IDLE: at a clock edge with any request pending, select the winner:
  - default priority: DM over IF.
  - go to BUSY_x; latch addr/we/wdata into mem_*; assert mem_req.
  - IF grant always drives mem_we=0 and mem_wdata=0.
- BUSY_x: mem_req held high; mem_* held stable.
  - mem_ack=1 at an edge: capture mem_rdata into x_rdata; pulse x_ack=1 for the following cycle; drop mem_req/mem_we; go to DONE.
- DONE: exactly one cycle; ack pulse visible; next edge -> IDLE. This gap keeps a still-high req from being re-granted.
- Latency: req high at edge N -> mem_req=1 in cycle after N; mem_ack at edge M -> x_ack in cycle after M. Minimum req-to-req spacing is 3 cycles + memory latency.
- Timeout:
  - Counter counts BUSY cycles without mem_ack and clears on entering BUSY.
  - On reaching TIMEOUT: drop mem_req; x_ack pulse with x_rdata=0; timeout_err=1 (sticky until reset); go to DONE.
  - mem_ack on the same edge as the timeout takes precedence: normal completion, no error.
- mem_ack in IDLE or DONE is ignored.
- Write data is not returned: dm_rdata keeps its previous value on a write ack.
- Reset mid-transaction: mem_req drops asynchronously; no ack pulse is emitted after release.
- Requester dropping req before its ack: violation; the arbiter still completes the access and pulses ack.

Optional Feature:
- Macro: MCPU_ARB_RR_EN.
- Defined: a 1-bit last-grant pointer (updated on every grant) makes simultaneous IF+DM requests alternate, granting the requester not served last.
- Undefined: fixed priority, DM always wins ties; IF is granted only when dm_req=0 in IDLE.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset: rst=0 with both reqs high -> all outputs 0; after rst=1 with no reqs, mem_req stays 0 for 20 cycles.
- Single fetch: if_req, if_addr=0x0010; memory acks 2 cycles later with 0x1234 -> mem_addr=0x0010, mem_we=0; one-cycle if_ack with if_rdata=0x1234; stall_if high until the ack cycle.
- Tie, default build: both requests at the same edge, DM write 0x8000/0xBEEF, IF 0x0020 -> first mem_req has mem_we=1, addr 0x8000, wdata 0xBEEF; dm_ack; then DONE, IDLE, IF grant at 0x0020.
- Tie, MCPU_ARB_RR_EN build: four back-to-back simultaneous request pairs -> grant order DM, IF, DM, IF... starting from pointer=IF after reset, so DM first.
- Timeout: DM read with mem_ack never asserted, TIMEOUT=15 -> mem_req falls after 15 BUSY cycles; dm_ack pulse with dm_rdata=0x0000; timeout_err=1 and stays 1.
- Reset mid-access: rst=0 two cycles into BUSY_IF -> mem_req=0 immediately; after release no if_ack; a re-issued if_req completes normally.
